cache_mem_arb: RTL and testbench

- Arbiter and sequencer for the single-ported cache data SRAM. It shares the port between the line-level controllers: read controller, write controller and snoop/message responder.
- Each cycle it grants at most one read or write using a 2-bit requester priority, round-robin among equal priorities, and a starvation boost.
- It tracks in-flight reads and returns each read's data valid to the requester that issued it, RD_LAT cycles after grant.

---
 rtl/cache_mem_arb.sv | 128 ++++++++++++
 tb/tb_cache_mem_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arb.sv
// rtl/cache_mem_arb.sv - priority/round-robin arbiter and read-return sequencer
// for the single-ported cache data SRAM shared by the line-level controllers.
module cache_mem_arb #(
   parameter int LIST_DEPTH   = 4,
   parameter int LIST_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REQ      = 3,
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 8,
   localparam int AW = $clog2(LIST_DEPTH) + $clog2(LIST_WIDTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          arb_hold,
   input  logic [NUM_REQ-1:0]            req_ren,
   input  logic [NUM_REQ-1:0]            req_wen,
   input  logic [NUM_REQ*AW-1:0]         req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*2-1:0]          req_pri,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         req_rdata,
   output logic [NUM_REQ-1:0]            req_rdata_valid,
   output logic                          sram_en,
   output logic                          sram_we,
   output logic [AW-1:0]                 sram_addr,
   output logic [DATA_WIDTH-1:0]         sram_wdata,
   input  logic [DATA_WIDTH-1:0]         sram_rdata
);

   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW  = $clog2(STARVE_LIMIT + 1);

   logic [NUM_REQ-1:0] active;
   logic [2:0]         epri [NUM_REQ];
   logic [2:0]         max_pri;
   logic [IDW-1:0]     rr_q, rr_d, winner;
   logic [CW-1:0]      wait_q [NUM_REQ];
   logic [CW-1:0]      wait_d [NUM_REQ];
   logic               grant, grant_rd, found;
   int                 scan_idx;
   logic               vld_q [RD_LAT];
   logic [IDW-1:0]     id_q  [RD_LAT];

   assign active = req_ren | req_wen;

   // A starved requester is lifted above every programmable priority.
   always_comb begin
      max_pri = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         epri[i] = (wait_q[i] == CW'(STARVE_LIMIT)) ? 3'd4 : {1'b0, req_pri[2*i +: 2]};
         if (active[i] && epri[i] > max_pri) max_pri = epri[i];
      end
   end

   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = (int'(rr_q) + k) % NUM_REQ;
         if (!found && active[scan_idx] && epri[scan_idx] == max_pri) begin
            found  = 1'b1;
            winner = IDW'(scan_idx);
         end
      end
   end

   assign grant    = !arb_hold && found;
   assign grant_rd = grant && !req_wen[winner];

   always_comb begin
      req_ready  = '0;
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (grant) begin
         req_ready[winner] = 1'b1;
         sram_en           = 1'b1;
         sram_we           = req_wen[winner];
         sram_addr         = req_addr[int'(winner)*AW +: AW];
         sram_wdata        = req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (grant) rr_d = (int'(winner) == NUM_REQ-1) ? '0 : winner + 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         wait_d[i] = wait_q[i];
         if (!active[i] || (grant && winner == IDW'(i)))
            wait_d[i] = '0;
         else if (wait_q[i] != CW'(STARVE_LIMIT))
            wait_d[i] = wait_q[i] + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            vld_q[s] <= 1'b0;
            id_q[s]  <= '0;
         end
      end else begin
         rr_q <= rr_d;
         for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
         vld_q[0] <= grant_rd;
         id_q[0]  <= winner;
         for (int s = 1; s < RD_LAT; s++) begin
            vld_q[s] <= vld_q[s-1];
            id_q[s]  <= id_q[s-1];
         end
      end
   end

   // Read data is not registered here; the SRAM output is already aligned with the strobe.
   assign req_rdata = sram_rdata;

   always_comb begin
      req_rdata_valid = '0;
      if (vld_q[RD_LAT-1]) req_rdata_valid[id_q[RD_LAT-1]] = 1'b1;
   end

   a_no_rw_both : assert property (@(posedge clk) disable iff (!rst_n) (req_ren & req_wen) == '0);

endmodule

// File: tb/tb_cache_mem_arb.sv
// tb/tb_cache_mem_arb.sv - randomized and directed self-checking bench for cache_mem_arb
module tb_cache_mem_arb;

   localparam int N      = 3;
   localparam int DW     = 32;
   localparam int RD_LAT = 2;
   localparam int SL     = 3;
   localparam int AW     = 7;
   localparam int WORDS  = 1 << AW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, arb_hold;
   logic [N-1:0]      req_ren, req_wen;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N*2-1:0]    req_pri;
   logic [N-1:0]      req_ready, req_rdata_valid;
   logic [DW-1:0]     req_rdata, sram_wdata, sram_rdata;
   logic              sram_en, sram_we;
   logic [AW-1:0]     sram_addr;

   cache_mem_arb #(.LIST_DEPTH(4), .LIST_WIDTH(32), .DATA_WIDTH(DW), .NUM_REQ(N),
                   .RD_LAT(RD_LAT), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst_n(rst_n), .arb_hold(arb_hold),
      .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_pri(req_pri), .req_ready(req_ready),
      .req_rdata(req_rdata), .req_rdata_valid(req_rdata_valid),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata));

   typedef struct { int due; int id; logic [DW-1:0] data; } rd_t;

   int            n_cmp = 0, n_err = 0, cyc = 0;
   int            m_rr;
   int            m_wait [N];
   logic [DW-1:0] m_mem    [WORDS];
   logic [DW-1:0] sram_mem [WORDS];
   logic [DW-1:0] dl       [RD_LAT];
   rd_t           m_rq[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Winner = highest effective priority, ties broken by cyclic distance from the pointer.
   function automatic int model_winner();
      int best = -1;
      int bkey = -1000;
      for (int i = 0; i < N; i++) begin
         if (req_ren[i] | req_wen[i]) begin
            int ep, key;
            ep  = (m_wait[i] >= SL) ? 4 : int'(req_pri[2*i +: 2]);
            key = ep * N - ((i - m_rr + N) % N);
            if (key > bkey) begin
               bkey = key;
               best = i;
            end
         end
      end
      return best;
   endfunction

   task automatic set_req(input int i, input bit wr, input int addr, input int pri);
      req_ren[i]            = !wr;
      req_wen[i]            = wr;
      req_addr[i*AW +: AW]  = AW'(addr);
      req_wdata[i*DW +: DW] = $urandom;
      req_pri[2*i +: 2]     = 2'(pri);
   endtask

   task automatic drop(input int i);
      req_ren[i] = 1'b0;
      req_wen[i] = 1'b0;
   endtask

   task automatic step(output int w);
      logic [N-1:0]  exp_rdy, exp_v;
      logic          cap_en, cap_we;
      logic [AW-1:0] cap_addr;
      logic [DW-1:0] cap_wd;
      int            addr;
      @(negedge clk);
      w = arb_hold ? -1 : model_winner();
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("ready", req_ready, exp_rdy);
      chk("sram_en", sram_en, 64'(w >= 0));
      if (w >= 0) begin
         chk("sram_we", sram_we, req_wen[w]);
         chk("sram_addr", sram_addr, req_addr[w*AW +: AW]);
         if (req_wen[w]) chk("sram_wdata", sram_wdata, req_wdata[w*DW +: DW]);
      end else begin
         chk("idle_we", sram_we, 0);
         chk("idle_addr", sram_addr, 0);
      end
      exp_v = '0;
      if (m_rq.size() > 0 && m_rq[0].due == cyc) begin
         exp_v[m_rq[0].id] = 1'b1;
         chk("rdata", req_rdata, m_rq[0].data);
         void'(m_rq.pop_front());
      end
      chk("rdata_valid", req_rdata_valid, exp_v);
      cap_en = sram_en; cap_we = sram_we; cap_addr = sram_addr; cap_wd = sram_wdata;
      if (w >= 0) begin
         addr = int'(req_addr[w*AW +: AW]);
         if (req_wen[w]) m_mem[addr] = req_wdata[w*DW +: DW];
         else            m_rq.push_back('{cyc + RD_LAT, w, m_mem[addr]});
         m_rr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         if (!(req_ren[i] | req_wen[i]) || i == w) m_wait[i] = 0;
         else if (m_wait[i] < SL)                  m_wait[i]++;
      end
      @(posedge clk);
      for (int k = RD_LAT-1; k > 0; k--) dl[k] = dl[k-1];
      dl[0] = cap_en ? sram_mem[cap_addr] : '0;
      if (cap_en && cap_we) sram_mem[cap_addr] = cap_wd;
      sram_rdata = dl[RD_LAT-1];
      cyc++;
      #1;
   endtask

   task automatic reset_phase(input int n);
      rst_n = 1'b0; req_ren = '0; req_wen = '0; arb_hold = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("rst_ready", req_ready, 0);
         chk("rst_sram_en", sram_en, 0);
         chk("rst_valid", req_rdata_valid, 0);
      end
      rst_n = 1'b1;
      m_rq.delete();
      m_rr = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w, starve_k;
      int pri_exp [3];
      rst_n = 1'b0; arb_hold = 1'b0; req_ren = '0; req_wen = '0;
      req_addr = '0; req_wdata = '0; req_pri = '0; sram_rdata = '0;
      for (int a = 0; a < WORDS; a++) begin
         m_mem[a]    = $urandom;
         sram_mem[a] = m_mem[a];
      end
      for (int k = 0; k < RD_LAT; k++) dl[k] = '0;
      reset_phase(3);

      pri_exp = '{1, 2, 0};
      set_req(0, 1'b0, 'h25, 0);
      set_req(1, 1'b1, 'h11, 2);
      set_req(2, 1'b0, 'h40, 1);
      for (int k = 0; k < 3; k++) begin
         step(w);
         chk("pri_order", w, pri_exp[k]);
         if (w >= 0) drop(w);
      end
      repeat (3) step(w);

      for (int i = 0; i < N; i++) set_req(i, 1'b0, $urandom_range(0, WORDS-1), 1);
      for (int k = 0; k < 6; k++) begin
         step(w);
         chk("rr_seq", w, (k + 1) % N);
      end
      req_ren = '0;
      repeat (3) step(w);

      starve_k = -1;
      set_req(0, 1'b1, 'h05, 3);
      set_req(2, 1'b0, 'h33, 0);
      for (int k = 0; k < 8; k++) begin
         step(w);
         if (w == 2) begin
            if (starve_k < 0) starve_k = k;
            drop(2);
         end
      end
      chk("starve_grant_cycle", starve_k, SL);
      drop(0);
      repeat (3) step(w);

      set_req(1, 1'b0, 'h62, 0);
      step(w);
      chk("hold_pre_grant", w, 1);
      drop(1);
      set_req(0, 1'b0, 'h1c, 2);
      arb_hold = 1'b1;
      repeat (3) step(w);
      arb_hold = 1'b0;
      step(w);
      chk("hold_release_grant", w, 0);
      drop(0);
      repeat (3) step(w);

      set_req(0, 1'b0, 'h07, 1);
      step(w);
      reset_phase(2);
      for (int i = 0; i < N; i++) set_req(i, 1'b0, $urandom_range(0, WORDS-1), 1);
      step(w);
      chk("post_reset_grant", w, 0);
      req_ren = '0;
      repeat (3) step(w);

      for (int c = 0; c < 1500; c++) begin
         step(w);
         if (w >= 0) drop(w);
         for (int i = 0; i < N; i++)
            if (!(req_ren[i] | req_wen[i]) && $urandom_range(0, 1) == 1)
               set_req(i, $urandom_range(0, 2) == 0, $urandom_range(0, WORDS-1), $urandom_range(0, 3));
         arb_hold = ($urandom_range(0, 9) == 0);
      end
      arb_hold = 1'b0; req_ren = '0; req_wen = '0;
      repeat (RD_LAT + 2) step(w);
      chk("pending_reads_drained", m_rq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
